// File: rtl/dmem_resp_pkg.sv
// Shared defines for the data-memory responder: bus widths, enable encodings
// and the responder FSM state type.
package dmem_resp_pkg;

  localparam int RegBus      = 32;
  localparam int InstAddrBus = 32;

  localparam logic ChipEnable   = 1'b1;
  localparam logic ChipDisable  = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic [RegBus-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  function automatic logic is_misaligned(input logic [1:0] byte_lsb);
    return byte_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM; write and registered read share one edge.
module dmem_array
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [RegBus-1:0] wdata,
  output logic [RegBus-1:0] rdata
);

  logic [RegBus-1:0] mem [DEPTH];

  // Read-before-write: a store edge returns the old word, which the
  // responder never presents for a store.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: serves one load/store after WAIT_CYCLES wait states.
// Optional misaligned-access checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mem_ce_i,
  input  logic                   mem_we_i,
  input  logic [InstAddrBus-1:0] mem_addr_i,
  input  logic [RegBus-1:0]      mem_data_i,
  output logic [RegBus-1:0]      mem_rdata_o,
  output logic                   mem_ack_o,
  output logic                   stall_req_o,
  output logic                   mem_err_o
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LD  = 4'(WAIT_CYCLES);

  dmem_state_e       state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              we_reg;
  logic [AW-1:0]     idx_reg;
  logic [RegBus-1:0] wdata_reg;
  logic              mis_reg;
  logic [RegBus-1:0] rdata_hold_reg;

  logic              take;
  logic              commit;
  logic              in_mis;
  logic              eff_we;
  logic [AW-1:0]     eff_idx;
  logic [RegBus-1:0] eff_wdata;
  logic              eff_mis;
  logic              arr_we;
  logic [RegBus-1:0] arr_rdata;
  logic [RegBus-1:0] load_data;
  logic              unused_addr;

  // Upper address bits alias; the low two only matter for alignment checking.
  assign unused_addr = ^{mem_addr_i[InstAddrBus-1:AW+2], mem_addr_i[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign in_mis = is_misaligned(mem_addr_i[1:0]);
`else
  assign in_mis = 1'b0;
`endif

  assign take = (state_reg == DMEM_IDLE) && (mem_ce_i == ChipEnable);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    commit     = 1'b0;
    case (state_reg)
      DMEM_IDLE: begin
        if (take) begin
          cnt_next = WAIT_LD;
          if (WAIT_CYCLES == 0) begin
            state_next = DMEM_RESP;
            commit     = 1'b1;
          end else begin
            state_next = DMEM_WAIT;
          end
        end
      end
      DMEM_WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = DMEM_RESP;
          commit     = 1'b1;
        end
      end
      DMEM_RESP: state_next = DMEM_IDLE;
      default:   state_next = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= DMEM_IDLE;
      cnt_reg        <= 4'd0;
      we_reg         <= WriteDisable;
      idx_reg        <= '0;
      wdata_reg      <= ZeroWord;
      mis_reg        <= 1'b0;
      rdata_hold_reg <= ZeroWord;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      rdata_hold_reg <= mem_rdata_o;
      if (take) begin
        we_reg    <= mem_we_i;
        idx_reg   <= mem_addr_i[AW+1:2];
        wdata_reg <= mem_data_i;
        mis_reg   <= in_mis;
      end
    end
  end

  // With zero wait states the commit edge is the capture edge, so the RAM is
  // fed straight from the request port while idle.
  assign eff_we    = (state_reg == DMEM_IDLE) ? mem_we_i   : we_reg;
  assign eff_idx   = (state_reg == DMEM_IDLE) ? mem_addr_i[AW+1:2] : idx_reg;
  assign eff_wdata = (state_reg == DMEM_IDLE) ? mem_data_i : wdata_reg;
  assign eff_mis   = (state_reg == DMEM_IDLE) ? in_mis     : mis_reg;

  assign arr_we = commit && (eff_we == WriteEnable) && !eff_mis && rst_n;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (eff_idx),
    .wdata (eff_wdata),
    .rdata (arr_rdata)
  );

  assign load_data   = mis_reg ? ZeroWord : arr_rdata;
  assign mem_rdata_o = ((state_reg == DMEM_RESP) && (we_reg == WriteDisable))
                       ? load_data : rdata_hold_reg;
  assign mem_ack_o   = (state_reg == DMEM_RESP);
  assign stall_req_o = take || (state_reg == DMEM_WAIT);

`ifdef DMEM_ALIGN_CHECK_EN
  assign mem_err_o = (state_reg == DMEM_RESP) && mis_reg;
`else
  assign mem_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: three instances (0, 1 and 15 wait states) checked
// cycle by cycle against a word-array model of the responder.
module tb_dmem_resp;

  localparam int NI    = 3;
  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst_n;
  logic        ce    [NI];
  logic        we    [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic [31:0] rdata [NI];
  logic        ack   [NI];
  logic        stall [NI];
  logic        err   [NI];

  logic [31:0] model_mem  [NI][DEPTH];
  logic [31:0] last_rdata [NI];

  int checks = 0;
  int errors = 0;

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 15;
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    dmem_resp #(
      .DEPTH       (DEPTH),
      .WAIT_CYCLES ((gi == 0) ? 0 : (gi == 1) ? 1 : 15)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_ce_i    (ce[gi]),
      .mem_we_i    (we[gi]),
      .mem_addr_i  (addr[gi]),
      .mem_data_i  (wdata[gi]),
      .mem_rdata_o (rdata[gi]),
      .mem_ack_o   (ack[gi]),
      .stall_req_o (stall[gi]),
      .mem_err_o   (err[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request on instance k; checks stall/ack/rdata/err every cycle up to the ack.
  task automatic xact(input int k, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input bit drop_ce);
    int          wc;
    int          idx;
    bit          mis;
    logic [31:0] exp_rd;
    wc  = wait_of(k);
    idx = int'((a / 32'd4) % DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
    mis = (a % 32'd4) != 0;
`else
    mis = 1'b0;
`endif
    ce[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    for (int c = 0; c <= wc + 1; c++) begin
      @(negedge clk);
      check($sformatf("k%0d stall c%0d", k, c), 32'(stall[k]), 32'(c <= wc));
      check($sformatf("k%0d ack c%0d", k, c), 32'(ack[k]), 32'(c == wc + 1));
      if (c == wc + 1) begin
        exp_rd = w ? last_rdata[k] : (mis ? 32'h0 : model_mem[k][idx]);
        check($sformatf("k%0d rdata resp", k), rdata[k], exp_rd);
        check($sformatf("k%0d err resp", k), 32'(err[k]), 32'(mis));
        last_rdata[k] = exp_rd;
        if (w && !mis) model_mem[k][idx] = d;
      end else begin
        check($sformatf("k%0d rdata hold c%0d", k, c), rdata[k], last_rdata[k]);
        check($sformatf("k%0d err idle c%0d", k, c), 32'(err[k]), 32'h0);
      end
      @(posedge clk);
      #1;
      if (c < wc) we[k] = 1'($urandom);
    end
    if (drop_ce) ce[k] = 1'b0;
    $display("XACT k=%0d %s addr=%08h data=%08h rdata=%08h mis=%0d",
             k, w ? "ST" : "LD", a, d, last_rdata[k], mis);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      ce[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
      last_rdata[k] = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("k%0d reset rdata", k), rdata[k], 32'h0);
      check($sformatf("k%0d reset ack", k), 32'(ack[k]), 32'h0);
      check($sformatf("k%0d reset stall", k), 32'(stall[k]), 32'h0);
      check($sformatf("k%0d reset err", k), 32'(err[k]), 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known contents for words 0..8 of every instance
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 9; i++)
        xact(k, 1'b1, 32'(i * 4), $urandom, 1'b1);

    // Store then load on the one-wait-state instance
    xact(1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
    xact(1, 1'b0, 32'h10, 32'h0, 1'b1);
    @(negedge clk);
    check("deadbeef load", rdata[1], 32'hDEADBEEF);
    @(posedge clk); #1;

    // Back-to-back loads with ce held high on the zero-wait instance
    xact(0, 1'b0, 32'h0, 32'h0, 1'b0);
    xact(0, 1'b0, 32'h4, 32'h0, 1'b1);
    @(negedge clk);
    check("b2b no extra ack", 32'(ack[0]), 32'h0);
    check("b2b no extra stall", 32'(stall[0]), 32'h0);
    @(posedge clk); #1;

    // Address wrap: byte DEPTH*4 aliases word 0
    xact(1, 1'b1, 32'h1000, 32'h1234, 1'b1);
    xact(1, 1'b0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    check("wrap load", rdata[1], 32'h1234);
    @(posedge clk); #1;

    // Misaligned store, then aligned load of the same word
    xact(1, 1'b1, 32'h6, 32'hFFFF, 1'b1);
    xact(1, 1'b0, 32'h4, 32'h0, 1'b1);

    // Reset in the middle of the wait phase of a store
    ce[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'hA5A5;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    ce[2] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("k%0d midwait rdata", k), rdata[k], 32'h0);
      check($sformatf("k%0d midwait ack", k), 32'(ack[k]), 32'h0);
      check($sformatf("k%0d midwait stall", k), 32'(stall[k]), 32'h0);
      check($sformatf("k%0d midwait err", k), 32'(err[k]), 32'h0);
      last_rdata[k] = '0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xact(2, 1'b0, 32'h20, 32'h0, 1'b1);

    // Long wait: 16 stall cycles, ack in the 17th
    xact(2, 1'b0, 32'h8, 32'h0, 1'b1);

    // Randomized mix over the known words, with aliasing and low-bit noise
    for (int n = 0; n < 40; n++) begin
      int          k;
      logic        w;
      logic [31:0] a;
      k = $urandom_range(0, NI - 1);
      w = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 8) * 4 + $urandom_range(0, 3)
              + DEPTH * 4 * $urandom_range(0, 7));
      xact(k, w, a, $urandom, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
